// File: rtl/fb_pixel_writer.sv
// Framebuffer pixel writer: buffers clipped sprite pixels, drains them to the shared RAM port, owns full-screen clear.
// Optional: define FB_TRANSPARENT_SKIP_EN to treat colour 8'h00 as transparent (never pushed).
module fb_pixel_writer #(
   parameter int H_RES      = 640,
   parameter int V_RES      = 480,
   parameter int FIFO_DEPTH = 16,
   parameter int ADDR_W     = 19
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [9:0]        x_in,
   input  logic [9:0]        y_in,
   input  logic [7:0]        data_in,
   input  logic              write_enable_in,
   output logic              ready,
   input  logic              clear_start,
   input  logic [7:0]        clear_color,
   input  logic              mem_grant,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_data,
   output logic              mem_we,
   output logic              busy,
   output logic              overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = ADDR_W + 8;
   localparam logic [10:0]       LP_H    = 11'(H_RES);
   localparam logic [10:0]       LP_V    = 11'(V_RES);
   localparam logic [CNT_W-1:0]  LP_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(H_RES * V_RES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_CLEAR = 2'd2
   } state_t;

   state_t              r_state;
   logic [ENT_W-1:0]    r_fifo [FIFO_DEPTH];
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [CNT_W-1:0]    r_count;
   logic [ADDR_W-1:0]   r_clr_addr;
   logic [7:0]          r_clr_color;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [7:0]          r_mem_data;
   logic                r_busy;
   logic                r_overflow;

   logic                w_on_screen;
   logic                w_opaque;
   logic                w_valid;
   logic                w_full;
   logic                w_empty;
   logic                w_push;
   logic                w_pop;
   logic [ADDR_W-1:0]   w_addr;
   logic [CNT_W-1:0]    w_count_nxt;
   logic [ENT_W-1:0]    w_head;

   assign w_on_screen = ({1'b0, x_in} < LP_H) && ({1'b0, y_in} < LP_V);
`ifdef FB_TRANSPARENT_SKIP_EN
   assign w_opaque    = (data_in != 8'h00);
`else
   assign w_opaque    = 1'b1;
`endif
   assign w_valid     = write_enable_in & w_on_screen & w_opaque;
   assign w_full      = (r_count == LP_FULL);
   assign w_empty     = (r_count == {CNT_W{1'b0}});
   assign w_push      = w_valid & ~w_full;
   // Pops never happen while sweeping so queued pixels land after the clear.
   assign w_pop       = (r_state != ST_CLEAR) & mem_grant & ~w_empty;
   assign w_addr      = ADDR_W'(y_in) * ADDR_W'(H_RES) + ADDR_W'(x_in);
   assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
   assign w_head      = r_fifo[r_rd_ptr];

   assign ready    = ~w_full;
   assign mem_we   = r_mem_we;
   assign mem_addr = r_mem_addr;
   assign mem_data = r_mem_data;
   assign busy     = r_busy;
   assign overflow = r_overflow;

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_fifo[r_wr_ptr] <= {w_addr, data_in};
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_wr_ptr   <= {PTR_W{1'b0}};
         r_rd_ptr   <= {PTR_W{1'b0}};
         r_count    <= {CNT_W{1'b0}};
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count <= w_count_nxt;
         if (w_valid && w_full) begin
            r_overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= {ADDR_W{1'b0}};
         r_mem_data  <= 8'h00;
         r_busy      <= 1'b0;
         r_clr_addr  <= {ADDR_W{1'b0}};
         r_clr_color <= 8'h00;
      end else begin
         r_mem_we <= 1'b0;
         if (w_pop) begin
            r_mem_we   <= 1'b1;
            r_mem_addr <= w_head[ENT_W-1:8];
            r_mem_data <= w_head[7:0];
         end
         case (r_state)
            ST_IDLE: begin
               if (clear_start) begin
                  r_clr_color <= clear_color;
                  r_state     <= ST_DRAIN;
                  r_busy      <= 1'b1;
               end else begin
                  r_busy <= (w_count_nxt != {CNT_W{1'b0}});
               end
            end
            ST_DRAIN: begin
               r_busy <= 1'b1;
               if (w_empty) begin
                  r_state    <= ST_CLEAR;
                  r_clr_addr <= {ADDR_W{1'b0}};
               end
            end
            ST_CLEAR: begin
               if (mem_grant) begin
                  r_mem_we   <= 1'b1;
                  r_mem_addr <= r_clr_addr;
                  r_mem_data <= r_clr_color;
                  r_clr_addr <= r_clr_addr + ADDR_W'(1);
                  if (r_clr_addr == LP_LAST) begin
                     r_state <= ST_IDLE;
                     r_busy  <= (w_count_nxt != {CNT_W{1'b0}});
                  end else begin
                     r_busy <= 1'b1;
                  end
               end else begin
                  r_busy <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= (w_count_nxt != {CNT_W{1'b0}});
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Bench for fb_pixel_writer: a reduced 40x30 instance for full sweeps plus a default-size instance for address checks.
module tb_fb_pixel_writer;

   localparam int SH  = 40;
   localparam int SV  = 30;
   localparam int SN  = SH * SV;
`ifdef FB_TRANSPARENT_SKIP_EN
   localparam bit SKIP0 = 1'b1;
`else
   localparam bit SKIP0 = 1'b0;
`endif

   logic        clock;
   logic        reset;
   logic [9:0]  x_in;
   logic [9:0]  y_in;
   logic [7:0]  data_in;
   logic        write_enable_in;
   logic        clear_start;
   logic [7:0]  clear_color;
   logic        mem_grant;

   logic        s_ready, s_mem_we, s_busy, s_overflow;
   logic [10:0] s_mem_addr;
   logic [7:0]  s_mem_data;
   logic        b_ready, b_mem_we, b_busy, b_overflow;
   logic [18:0] b_mem_addr;
   logic [7:0]  b_mem_data;

   int          checks   = 0;
   int          fails    = 0;
   int          n_writes = 0;
   int          m_occ    = 0;
   bit          m_ovf    = 1'b0;
   logic [18:0] exp_q[$];
   logic [18:0] mon_e;
   int          base;
   bit          found;

   fb_pixel_writer #(.H_RES(SH), .V_RES(SV), .FIFO_DEPTH(16), .ADDR_W(11)) u_small (
      .clock(clock), .reset(reset), .x_in(x_in), .y_in(y_in), .data_in(data_in),
      .write_enable_in(write_enable_in), .ready(s_ready), .clear_start(clear_start),
      .clear_color(clear_color), .mem_grant(mem_grant), .mem_addr(s_mem_addr),
      .mem_data(s_mem_data), .mem_we(s_mem_we), .busy(s_busy), .overflow(s_overflow)
   );

   fb_pixel_writer u_full (
      .clock(clock), .reset(reset), .x_in(x_in), .y_in(y_in), .data_in(data_in),
      .write_enable_in(write_enable_in), .ready(b_ready), .clear_start(clear_start),
      .clear_color(clear_color), .mem_grant(mem_grant), .mem_addr(b_mem_addr),
      .mem_data(b_mem_data), .mem_we(b_mem_we), .busy(b_busy), .overflow(b_overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One IDLE-mode cycle: apply a pixel, advance the reference occupancy, then check flags.
   task automatic drive(input bit v, input int x, input int y, input logic [7:0] d, input bit g);
      bit onscr, opq, acc, pop;
      x_in            = x[9:0];
      y_in            = y[9:0];
      data_in         = d;
      write_enable_in = v;
      mem_grant       = g;
      onscr = (x < SH) && (y < SV);
      opq   = !(SKIP0 && (d == 8'h00));
      acc   = v && onscr && opq && (m_occ < 16);
      if (v && onscr && opq && !acc) m_ovf = 1'b1;
      pop   = g && (m_occ > 0);
      if (acc) exp_q.push_back({11'(y * SH + x), d});
      m_occ = m_occ + int'(acc) - int'(pop);
      tick();
      write_enable_in = 1'b0;
      chk("ready", s_ready, m_occ != 16);
      chk("busy", s_busy, m_occ != 0);
      chk("overflow", s_overflow, m_ovf);
   endtask

   // Every write of the reduced instance must match the head of the expected sequence.
   always @(negedge clock) begin
      if (s_mem_we === 1'b1) begin
         n_writes++;
         checks++;
         assert (exp_q.size() != 0) else begin
            fails++;
            $error("FAIL extra_write observed=%0h expected=none", {s_mem_addr, s_mem_data});
         end
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("write_addr", s_mem_addr, mon_e[18:8]);
            chk("write_data", s_mem_data, mon_e[7:0]);
         end
      end
   end

   initial begin
      reset = 1'b0; x_in = 10'd0; y_in = 10'd0; data_in = 8'h00; write_enable_in = 1'b0;
      clear_start = 1'b0; clear_color = 8'h00; mem_grant = 1'b1;
      tick(); tick();
      chk("rst_we", s_mem_we, 1'b0);
      chk("rst_addr", s_mem_addr, 11'd0);
      chk("rst_data", s_mem_data, 8'h00);
      chk("rst_busy", s_busy, 1'b0);
      chk("rst_ovf", s_overflow, 1'b0);
      chk("rst_ready", s_ready, 1'b1);
      chk("rst_ready_full", b_ready, 1'b1);
      reset = 1'b1;
      tick();

      // Single pixel latency and address on the full-size instance.
      drive(1'b1, 5, 2, 8'h3C, 1'b1);
      chk("lat_busy_full", b_busy, 1'b1);
      drive(1'b0, 0, 0, 8'h00, 1'b1);
      chk("lat_we_full", b_mem_we, 1'b1);
      chk("lat_addr_full", b_mem_addr, 19'd1285);
      chk("lat_data_full", b_mem_data, 8'h3C);
      drive(1'b0, 0, 0, 8'h00, 1'b1);
      chk("idle_busy_full", b_busy, 1'b0);
      chk("idle_we_full", b_mem_we, 1'b0);

      // Colour zero: transparent only with the skip feature.
      drive(1'b1, 1, 1, 8'h00, 1'b1);
      drive(1'b0, 0, 0, 8'h00, 1'b1);
      chk("zero_we_full", b_mem_we, !SKIP0);
      chk("zero_addr_full", b_mem_addr, SKIP0 ? 19'd1285 : 19'd641);
      chk("zero_data_full", b_mem_data, SKIP0 ? 8'h3C : 8'h00);
      drive(1'b0, 0, 0, 8'h00, 1'b1);

      // Clipping on the reduced instance, including the last visible pixel.
      drive(1'b1, 640, 0, 8'h11, 1'b1);
      drive(1'b1, 0, 480, 8'h12, 1'b1);
      drive(1'b1, SH, 0, 8'h13, 1'b1);
      drive(1'b1, 0, SV, 8'h14, 1'b1);
      drive(1'b1, 1023, 1023, 8'h15, 1'b1);
      drive(1'b1, SH - 1, SV - 1, 8'h16, 1'b1);
      drive(1'b0, 0, 0, 8'h00, 1'b1);
      drive(1'b0, 0, 0, 8'h00, 1'b1);
      chk("clip_done", exp_q.size(), 0);

      // Fill with grant low, then overflow with a simultaneous pop.
      for (int i = 0; i < 16; i++) drive(1'b1, i + 3, 7, 8'(i + 1), 1'b0);
      chk("full_ready", s_ready, 1'b0);
      base = n_writes;
      drive(1'b1, 9, 9, 8'hAA, 1'b1);
      chk("ovf_set", s_overflow, 1'b1);
      while (m_occ > 0) drive(1'b0, 0, 0, 8'h00, 1'b1);
      drive(1'b0, 0, 0, 8'h00, 1'b1);
      chk("ovf_writes", n_writes - base, 16);
      chk("ovf_queue", exp_q.size(), 0);

      // Random pixels with sparse grant against the occupancy model.
      for (int i = 0; i < 300; i++)
         drive($urandom_range(0, 9) < 6, int'($urandom_range(0, 47)), int'($urandom_range(0, 35)),
               8'($urandom_range(0, 255)), $urandom_range(0, 9) < 3);
      while (m_occ > 0) drive(1'b0, 0, 0, 8'h00, 1'b1);
      drive(1'b0, 0, 0, 8'h00, 1'b1);
      chk("rand_queue", exp_q.size(), 0);

      // Clear with three queued pixels, a late second clear_start and pixels pushed mid-sweep.
      for (int i = 0; i < 3; i++) drive(1'b1, 10 + i, 4, 8'h50 + 8'(i), 1'b0);
      clear_start = 1'b1; clear_color = 8'hE0; mem_grant = 1'b1;
      for (int a = 0; a < SN; a++) exp_q.push_back({11'(a), 8'hE0});
      tick();
      clear_start = 1'b0;
      chk("clr_busy", s_busy, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         mem_grant       = (i < 10) ? 1'b1 : ($urandom_range(0, 3) != 0);
         write_enable_in = (i == 50) || (i == 51);
         x_in            = (i == 51) ? 10'd21 : 10'd20;
         y_in            = 10'd3;
         data_in         = (i == 51) ? 8'h78 : 8'h77;
         if (i == 50) exp_q.push_back({11'd140, 8'h77});
         if (i == 51) exp_q.push_back({11'd141, 8'h78});
         clear_start     = (i == 60);
         clear_color     = (i == 60) ? 8'h11 : 8'hE0;
         tick();
         if (i > 60 && s_busy === 1'b0) begin
            found = 1'b1;
            break;
         end
      end
      write_enable_in = 1'b0; clear_start = 1'b0; mem_grant = 1'b1;
      tick();
      m_occ = 0;
      chk("clr_finished", found, 1'b1);
      chk("clr_queue", exp_q.size(), 0);

      // Reset while the sweep counter is at 1000.
      clear_start = 1'b1; clear_color = 8'h5A; mem_grant = 1'b1;
      for (int a = 0; a < 1000; a++) exp_q.push_back({11'(a), 8'h5A});
      tick();
      clear_start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (s_mem_we === 1'b1 && s_mem_addr === 11'd999) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      chk("abort_reached", found, 1'b1);
      reset = 1'b0;
      tick();
      chk("abort_we", s_mem_we, 1'b0);
      chk("abort_busy", s_busy, 1'b0);
      chk("abort_ready", s_ready, 1'b1);
      chk("abort_ovf", s_overflow, 1'b0);
      chk("abort_queue", exp_q.size(), 0);
      m_ovf = 1'b0;
      reset = 1'b1;
      base  = n_writes;
      repeat (20) tick();
      chk("abort_silent", n_writes - base, 0);
      drive(1'b1, SH - 1, SV - 1, 8'h42, 1'b1);
      drive(1'b0, 0, 0, 8'h00, 1'b1);
      drive(1'b0, 0, 0, 8'h00, 1'b1);
      chk("post_queue", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/fb_pixel_writer.md
Name: fb_pixel_writer

Overview:
- Downstream stage of the sprite serializer.
- Consumes its per-pixel stream (x, y, 8-bit colour, write enable) and buffers it in a small FIFO.
- Clips off-screen pixels, converts coordinates to a linear framebuffer address, and issues one write per granted cycle to the shared 640x480x8 framebuffer RAM port.
- Also owns the full-screen clear sequence, so sprite writes and clears never interleave out of order.

Parameters:
- H_RES, 640, visible columns; x valid range 0..H_RES-1.
- V_RES, 480, visible rows; y valid range 0..V_RES-1.
- FIFO_DEPTH, 16, pixel FIFO entries; power of two, at least 4.
- ADDR_W, 19, framebuffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- x_in  in  10  pixel column from serializer.
- y_in  in  10  pixel row from serializer.
- data_in  in  8  pixel colour.
- write_enable_in  in  1  pixel valid this cycle.
- ready  out  1  FIFO not full, combinational from count.
- clear_start  in  1  one-cycle request to fill the screen.
- clear_color  in  8  fill colour, sampled on accepted clear_start.
- mem_grant  in  1  RAM port available this cycle; VGA read side has priority when low.
- mem_addr  out  ADDR_W  write address.
- mem_data  out  8  write data.
- mem_we  out  1  write strobe, asserted only when mem_grant=1.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- overflow  out  1  sticky: a valid pixel was dropped because the FIFO was full.

Behaviour:
- Reset (reset=0 at a clock edge):
  - FIFO emptied; FSM to IDLE.
  - mem_we=0, mem_addr=0, mem_data=0, overflow=0, busy=0; ready=1 after reset.
  - Reset mid-clear or mid-drain aborts immediately with no further writes.
- Push rules:
  - Pixel is pushed when write_enable_in=1, x_in<H_RES, y_in<V_RES and FIFO not full.
  - Off-screen pixels are silently discarded; they do not set overflow.
  - Valid pixel arriving while full is dropped and overflow is set; overflow clears only on reset.
- Address arithmetic:
  - Address computed before storage: addr = y_in*H_RES + x_in, truncated to ADDR_W bits.
  - FIFO entry = {addr, data}.
- FIFO mechanics:
  - Registered read/write pointers, FIFO_DEPTH-entry count, wrap-around via pointer LSBs.
  - Simultaneous push and pop when full: pop happens, push is still rejected (ready was 0), count drops by 1.
  - Simultaneous push and pop when empty: pop not possible; entry appears next cycle.
- FSM IDLE:
  - If mem_grant=1 and FIFO non-empty: pop, drive mem_we=1, mem_addr/mem_data = head entry, registered.
  - Latency: pixel pushed at edge N is written at edge N+1 at earliest, given grant and an empty FIFO.
  - mem_grant=0 stalls pops; the FIFO holds.
  - clear_start=1: latch clear_color, go to DRAIN. If a pop also qualifies that cycle, it still completes.
- FSM DRAIN:
  - Continue popping as in IDLE.
  - When FIFO empty and no write in flight, go to CLEAR with sweep counter=0.
- FSM CLEAR:
  - Each cycle with mem_grant=1: mem_we=1, mem_addr=counter, mem_data=latched colour, counter+1.
  - No FIFO pops; pushes continue to be accepted until full.
  - After writing address H_RES*V_RES-1, return to IDLE. A clear therefore takes exactly 307200 granted cycles at default size.
- clear_start in DRAIN or CLEAR is ignored; colour not re-latched.
- mem_we=0 in any cycle where mem_grant=0 or nothing is to be written.
- busy is registered: 1 whenever FSM is not IDLE or count is non-zero.

Optional Feature:
- Macro: FB_TRANSPARENT_SKIP_EN
- Defined: pixels with data_in==8'h00 are not pushed, so colour 0 is transparent and sprite backgrounds do not overwrite the scene. They never set overflow. Clear colour 0 is still written by CLEAR.
- Undefined: colour 0 is treated as an ordinary colour and written like any other.

Test Plan:
- Reset then push (x=5,y=2,data=8'h3C), mem_grant=1 -> next edge mem_we=1, mem_addr=1285, mem_data=8'h3C; busy back to 0 the following cycle.
- Push x=640,y=0 and x=0,y=480 -> no write, overflow stays 0, count stays 0.
- mem_grant=0, push 17 valid pixels back-to-back -> ready falls after 16th, 17th dropped, overflow=1; raise grant -> exactly 16 writes in push order.
- 3 pixels queued, clear_start with clear_color=8'hE0 -> 3 pixel writes first, then addresses 0..307199 with 8'hE0, then IDLE; second clear_start mid-sweep has no effect.
- Assert reset during CLEAR at counter=1000 -> mem_we=0 next cycle, FSM IDLE, no further writes.
- With FB_TRANSPARENT_SKIP_EN: push data 8'h00 at (1,1) -> no write. Without it -> write addr 641 data 8'h00.
